clock_tick_divider: RTL

CLOCK_TICK_DIVIDER -- requirements
Module: clock_tick_divider

---
 rtl/clock_tick_divider.sv | 101 ++++++++++
 1 files changed

// File: rtl/clock_tick_divider.sv
// Clock tick divider: binary phase counter producing a duty-cycled square wave,
// a wrap tick and a midpoint tick, with a selectable fast rate.
module clock_tick_divider #(
    parameter int CLK_HZ    = 100000,
    parameter int OUT_HZ    = 1,
    parameter int FAST_MULT = 8,
    parameter int DUTY_PCT  = 50
) (
    input  logic                                  f_clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  fast,
    input  logic                                  resync,
    output logic                                  one_Hz,
    output logic                                  tick,
    output logic                                  half_tick,
    output logic [$clog2(CLK_HZ / OUT_HZ)-1:0]    phase
);

    localparam int DIV   = CLK_HZ / OUT_HZ;
    localparam int FDIV  = DIV / FAST_MULT;
    localparam int CNT_W = $clog2(DIV);

    // High-time in cycles for a period p, kept inside 1..p-1 so both levels exist.
    function automatic int high_cycles(input int p);
        int h;
        h = (p * DUTY_PCT) / 100;
        if (h < 1)
            h = 1;
        if (h > p - 1)
            h = p - 1;
        return h;
    endfunction

    localparam int DIV_LOW  = DIV - high_cycles(DIV);
    localparam int FDIV_LOW = FDIV - high_cycles(FDIV);

    localparam logic [CNT_W-1:0] DIV_LAST_C  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FDIV_LAST_C = CNT_W'(FDIV - 1);
    localparam logic [CNT_W-1:0] DIV_HALF_C  = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] FDIV_HALF_C = CNT_W'(FDIV / 2);
    localparam logic [CNT_W-1:0] DIV_LOW_C   = CNT_W'(DIV_LOW);
    localparam logic [CNT_W-1:0] FDIV_LOW_C  = CNT_W'(FDIV_LOW);

    generate
        if (DIV < 2 || FDIV < 2 || DUTY_PCT < 1 || DUTY_PCT > 99) begin : g_bad_params
            $error("clock_tick_divider: illegal parameters (DIV=%0d FDIV=%0d DUTY_PCT=%0d)",
                   DIV, FDIV, DUTY_PCT);
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] period_last;
    logic [CNT_W-1:0] period_half;
    logic [CNT_W-1:0] period_low;
    logic             fast_q;
    logic             wrap;

    // Period constants follow the registered mode; ">=" lets a stale count wrap at once.
    always_comb begin
        period_last = fast_q ? FDIV_LAST_C : DIV_LAST_C;
        period_half = fast_q ? FDIV_HALF_C : DIV_HALF_C;
        period_low  = fast_q ? FDIV_LOW_C  : DIV_LOW_C;
        wrap        = (cnt >= period_last);
        cnt_inc     = wrap ? '0 : cnt + CNT_W'(1);
    end

    // Priority: reset, resync, mode change, then normal counting.
    always_ff @(posedge f_clk) begin
        if (reset) begin
            cnt       <= '0;
            one_Hz    <= 1'b0;
            tick      <= 1'b0;
            half_tick <= 1'b0;
            fast_q    <= fast;
        end else if (resync) begin
            cnt       <= '0;
            one_Hz    <= 1'b0;
            tick      <= 1'b0;
            half_tick <= 1'b0;
        end else if (fast != fast_q) begin
            fast_q    <= fast;
            cnt       <= '0;
            one_Hz    <= 1'b0;
            tick      <= 1'b0;
            half_tick <= 1'b0;
        end else if (enable) begin
            cnt       <= cnt_inc;
            one_Hz    <= (cnt_inc >= period_low);
            tick      <= wrap;
            half_tick <= (cnt_inc == period_half);
        end else begin
            tick      <= 1'b0;
            half_tick <= 1'b0;
        end
    end

    assign phase = cnt;

endmodule
